// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: frame-level controller between UART RX, the ALU and UART TX.
// It collects three RX bytes in the order A, B, OPCODE and then commits them to the
// ALU operand registers. After ALU_LATENCY cycles it captures the ALU result and
// sends it out through the TX start/done handshake.
// Optional feature macro: ALU_SEQ_TIMEOUT_EN adds an inter-byte timeout. A partial
// frame is dropped when no byte arrives for TIMEOUT_CYCLES while waiting for B or OPCODE.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_rx_done, i_rx_data          received byte strobe and data
//   o_alu_a, o_alu_b, o_alu_op    registered ALU operands/opcode (last complete frame)
//   i_alu_result                  ALU result
//   o_tx_start, o_tx_data         TX start pulse and byte held until i_tx_done
//   i_tx_done                     TX finished pulse
//   o_busy                        high while executing or transmitting
//   o_done, o_overrun, o_frame_err one-cycle status pulses
module alu_uart_sequencer #(
    parameter int DATA_SIZE      = 8,
    parameter int OPCODE_SIZE    = 6,
    parameter int ALU_LATENCY    = 1,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMO_LEN        = 10
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_rx_done,
    input  logic [DATA_SIZE-1:0]   i_rx_data,
    output logic [DATA_SIZE-1:0]   o_alu_a,
    output logic [DATA_SIZE-1:0]   o_alu_b,
    output logic [OPCODE_SIZE-1:0] o_alu_op,
    input  logic [DATA_SIZE-1:0]   i_alu_result,
    output logic                   o_tx_start,
    output logic [DATA_SIZE-1:0]   o_tx_data,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_overrun,
    output logic                   o_frame_err
);
    localparam logic [2:0] WAIT_A  = 3'd0;
    localparam logic [2:0] WAIT_B  = 3'd1;
    localparam logic [2:0] WAIT_OP = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] TX      = 3'd4;
    localparam logic [2:0] TX_WAIT = 3'd5;
    localparam int LAT_W = $clog2(ALU_LATENCY + 1);

    logic [2:0]             state_q, state_d;
    logic [DATA_SIZE-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [DATA_SIZE-1:0]   a_q, a_d, b_q, b_d, txd_q, txd_d;
    logic [OPCODE_SIZE-1:0] op_q, op_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic                   done_q, done_d, ovr_q, ovr_d, ferr_q, ferr_d;
    logic                   busy;

    assign busy        = (state_q == EXEC) || (state_q == TX) || (state_q == TX_WAIT);
    assign o_busy      = busy;
    assign o_tx_start  = (state_q == TX);
    assign o_alu_a     = a_q;
    assign o_alu_b     = b_q;
    assign o_alu_op    = op_q;
    assign o_tx_data   = txd_q;
    assign o_done      = done_q;
    assign o_overrun   = ovr_q;
    assign o_frame_err = ferr_q;

`ifdef ALU_SEQ_TIMEOUT_EN
    logic [TMO_LEN-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        lat_d   = lat_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = i_rx_done && busy;
        case (state_q)
            WAIT_A: if (i_rx_done) begin
                sh_a_d  = i_rx_data;
                state_d = WAIT_B;
            end
            WAIT_B: if (i_rx_done) begin
                sh_b_d  = i_rx_data;
                state_d = WAIT_OP;
            end
            WAIT_OP: if (i_rx_done) begin
                a_d     = sh_a_q;
                b_d     = sh_b_q;
                op_d    = i_rx_data[OPCODE_SIZE-1:0];
                lat_d   = LAT_W'(ALU_LATENCY);
                state_d = EXEC;
            end
            EXEC: if (lat_q == LAT_W'(1)) begin
                txd_d   = i_alu_result;
                state_d = TX;
            end else begin
                lat_d   = lat_q - 1'b1;
            end
            TX: state_d = TX_WAIT;
            TX_WAIT: if (i_tx_done) begin
                done_d  = 1'b1;
                state_d = WAIT_A;
            end
            default: state_d = WAIT_A;
        endcase
`ifdef ALU_SEQ_TIMEOUT_EN
        tmo_d = '0;
        // Counter measures idle cycles since the last byte of a partial frame.
        if ((state_q == WAIT_B || state_q == WAIT_OP) && !i_rx_done) begin
            if (tmo_q == TMO_LEN'(TIMEOUT_CYCLES - 1)) begin
                sh_a_d  = '0;
                sh_b_d  = '0;
                ferr_d  = 1'b1;
                state_d = WAIT_A;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= WAIT_A;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            lat_q   <= '0;
            txd_q   <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            lat_q   <= lat_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) tmo_q <= '0;
        else          tmo_q <= tmo_d;
    end
`endif
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb_alu_uart_sequencer: self-checking bench with a cycle-timed frame model and adder ALU.
module tb_alu_uart_sequencer;
    localparam int L  = 1;
    localparam int TO = 100;

    logic       i_clk = 1'b0, i_reset = 1'b0, i_rx_done = 1'b0, i_tx_done = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic [7:0] o_alu_a, o_alu_b, o_tx_data, alu_result;
    logic [5:0] o_alu_op;
    logic       o_tx_start, o_busy, o_done, o_overrun, o_frame_err;

    int checks = 0, errors = 0, cyc = 0;

    alu_uart_sequencer #(
        .DATA_SIZE(8), .OPCODE_SIZE(6), .ALU_LATENCY(L), .TIMEOUT_CYCLES(TO), .TMO_LEN(10)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .i_alu_result(alu_result),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_done(i_tx_done),
        .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun), .o_frame_err(o_frame_err)
    );

    assign alu_result = o_alu_a + o_alu_b;

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: bytes pending, the cycle of the committing opcode, and pulses due next cycle.
    int         nb = 0, fc = 0, last_rx = 0;
    bit         in_frame = 0, done_p = 0, ovr_p = 0, ferr_p = 0;
    logic [7:0] pa = 0, pb = 0, ea = 0, eb = 0, res = 0, etxd = 0;
    logic [5:0] eop = 0;

    always @(negedge i_clk) begin
        cyc++;
        if (!i_reset) begin
            nb = 0; in_frame = 0; done_p = 0; ovr_p = 0; ferr_p = 0;
            pa = 0; pb = 0; ea = 0; eb = 0; eop = 0; etxd = 0; res = 0;
        end
        chk("alu_a", o_alu_a, ea);
        chk("alu_b", o_alu_b, eb);
        chk("alu_op", o_alu_op, eop);
        chk("tx_data", o_tx_data, etxd);
        chk("tx_start", o_tx_start, in_frame && cyc == fc + L + 1);
        chk("busy", o_busy, in_frame && cyc > fc);
        chk("done", o_done, done_p);
        chk("overrun", o_overrun, ovr_p);
        chk("frame_err", o_frame_err, ferr_p);
        if (i_reset) begin
            done_p = 0; ovr_p = 0; ferr_p = 0;
            if (in_frame && cyc > fc) begin
                if (cyc == fc + L) etxd = res;
                if (i_rx_done) ovr_p = 1;
                if (i_tx_done && cyc >= fc + L + 2) begin
                    done_p = 1;
                    in_frame = 0;
                end
            end else if (i_rx_done) begin
                last_rx = cyc;
                if (nb == 0) begin pa = i_rx_data; nb = 1; end
                else if (nb == 1) begin pb = i_rx_data; nb = 2; end
                else begin
                    ea = pa; eb = pb; eop = i_rx_data[5:0]; res = pa + pb;
                    fc = cyc; in_frame = 1; nb = 0;
                end
            end
`ifdef ALU_SEQ_TIMEOUT_EN
            else if (nb > 0 && cyc - last_rx >= TO) begin
                ferr_p = 1;
                nb = 0;
            end
`endif
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_done = 1'b1;
        i_rx_data = b;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send(a);
        send(b);
        send(op);
    endtask

    task automatic wait_start();
        int k = 0;
        while (!o_tx_start && k < 20) begin
            tick();
            k++;
        end
        chk("start_timeout", k < 20, 1);
    endtask

    task automatic ack();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    initial begin
        // 1: reset then idle
        repeat (3) tick();
        i_reset = 1'b1;
        repeat (50) tick();
        chk("idle_busy", o_busy, 0);
        chk("idle_txd", o_tx_data, 0);
        // 2: 5 + 3 with literal latency check
        frame(8'h05, 8'h03, 8'h20);
        chk("lat_exec", o_tx_start, 0);
        tick();
        chk("lat_start", o_tx_start, 1);
        chk("t2_txd", o_tx_data, 8'h08);
        chk("t2_a", o_alu_a, 8'h05);
        chk("t2_b", o_alu_b, 8'h03);
        chk("t2_op", o_alu_op, 6'h20);
        tick();
        ack();
        chk("t2_done", o_done, 1);
        chk("t2_busy", o_busy, 0);
        // tx_done outside TX_WAIT is ignored
        ack();
        tick();
        // 3: overrun in TX_WAIT, then next frame
        frame(8'h0A, 8'h0B, 8'h20);
        ack();
        wait_start();
        tick();
        send(8'h7F);
        chk("t3_overrun", o_overrun, 1);
        chk("t3_busy", o_busy, 1);
        ack();
        chk("t3_done", o_done, 1);
        frame(8'h01, 8'h02, 8'h20);
        wait_start();
        chk("t3_txd", o_tx_data, 8'h03);
        tick();
        // simultaneous rx and tx_done in TX_WAIT
        i_rx_done = 1'b1;
        i_rx_data = 8'h55;
        i_tx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        chk("sim_done", o_done, 1);
        chk("sim_ovr", o_overrun, 1);
        chk("sim_busy", o_busy, 0);
        // 4: reset mid-frame
        send(8'hAA);
        send(8'hBB);
        i_reset = 1'b0;
        repeat (2) tick();
        i_reset = 1'b1;
        tick();
        frame(8'h10, 8'h20, 8'h20);
        wait_start();
        chk("t4_a", o_alu_a, 8'h10);
        chk("t4_b", o_alu_b, 8'h20);
        chk("t4_txd", o_tx_data, 8'h30);
        tick();
        ack();
        // 6: opcode upper bits discarded
        frame(8'h02, 8'h03, 8'hE4);
        chk("t6_op", o_alu_op, 6'h24);
        wait_start();
        chk("t6_txd", o_tx_data, 8'h05);
        tick();
        ack();
`ifdef ALU_SEQ_TIMEOUT_EN
        // 5: partial frame dropped by timeout
        send(8'h11);
        repeat (TO - 1) tick();
        chk("t5_early", o_frame_err, 0);
        tick();
        chk("t5_ferr", o_frame_err, 1);
        chk("t5_a", o_alu_a, 8'h02);
        frame(8'h01, 8'h02, 8'h20);
        chk("t5_a_new", o_alu_a, 8'h01);
        wait_start();
        tick();
        ack();
`endif
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
